// File: rtl/incr9_share_arb_if.sv
// Request/response bundle between the Incr9 clients and the shared arbiter.
// The arbiter takes the slave side; the clients (or a bench) take the master side.
interface incr9_share_arb_if #(
   parameter int NREQ = 4
);
   localparam int IDW = $clog2(NREQ);

   logic [NREQ-1:0]   req_valid;
   logic [NREQ*9-1:0] req_data;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [8:0]        rsp_data;
   logic              rsp_cy;
   logic [IDW-1:0]    rsp_id;

   modport master (
      output req_valid, req_data, rsp_ready,
      input  req_ready, rsp_valid, rsp_data, rsp_cy, rsp_id
   );

   modport slave (
      input  req_valid, req_data, rsp_ready,
      output req_ready, rsp_valid, rsp_data, rsp_cy, rsp_id
   );
endinterface

// File: rtl/incr9_share_arb.sv
// Round-robin share of one 9-bit incrementor between NREQ requesters,
// with a single-entry registered result stage that reloads while draining.
module incr9_share_arb #(
   parameter int NREQ = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   incr9_share_arb_if.slave        bus_if
);
   localparam int IDW = $clog2(NREQ);
   localparam int PW  = IDW + 1;

   // Incrementor: bit i flips when every lower bit is one.
   function automatic logic [9:0] incr9(input logic [8:0] a);
      logic [8:0] carry;
      carry[0] = 1'b1;
      for (int i = 1; i < 9; i++) carry[i] = carry[i-1] & a[i-1];
      return {carry[8] & a[8], a ^ carry};
   endfunction

   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic            rsp_valid_q, rsp_valid_d;
   logic [8:0]      rsp_data_q, rsp_data_d;
   logic            rsp_cy_q, rsp_cy_d;
   logic [IDW-1:0]  rsp_id_q, rsp_id_d;

   logic            load_ok;
   logic            found;
   logic            accept;
   logic [IDW-1:0]  winner;
   logic [PW-1:0]   cand;
   logic [NREQ-1:0] grant_oh;
   logic [8:0]      operand;
   logic [9:0]      incr_res;

   assign load_ok = !rsp_valid_q || bus_if.rsp_ready;

   // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      cand   = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, rr_ptr_q} + PW'(k);
         if (cand >= PW'(NREQ)) cand = cand - PW'(NREQ);
         if (!found && bus_if.req_valid[cand[IDW-1:0]]) begin
            found  = 1'b1;
            winner = cand[IDW-1:0];
         end
      end
   end

   // Operand selection is an AND-OR mux on the one-hot grant feeding the single incrementor.
   always_comb begin
      grant_oh = '0;
      if (found) grant_oh[winner] = 1'b1;
      operand = '0;
      for (int i = 0; i < NREQ; i++) begin
         operand = operand | (bus_if.req_data[9*i +: 9] & {9{grant_oh[i]}});
      end
   end

   assign incr_res = incr9(operand);
   assign accept   = found && load_ok && !rst;

   always_comb begin
      rr_ptr_d    = rr_ptr_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_cy_d    = rsp_cy_q;
      rsp_id_d    = rsp_id_q;
      if (load_ok) rsp_valid_d = found;
      if (accept) begin
         rsp_data_d = incr_res[8:0];
         rsp_cy_d   = incr_res[9];
         rsp_id_d   = winner;
         rr_ptr_d   = (winner == IDW'(NREQ - 1)) ? '0 : winner + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_cy_q    <= 1'b0;
         rsp_id_q    <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_cy_q    <= rsp_cy_d;
         rsp_id_q    <= rsp_id_d;
      end
   end

   assign bus_if.req_ready = accept ? grant_oh : '0;
   assign bus_if.rsp_valid = rsp_valid_q;
   assign bus_if.rsp_data  = rsp_data_q;
   assign bus_if.rsp_cy    = rsp_cy_q;
   assign bus_if.rsp_id    = rsp_id_q;
endmodule

// File: tb/tb_incr9_share_arb.sv
// Self-checking bench for incr9_share_arb: scenario tasks plus a scoreboard
// fed by a reference model of arbitration and increment.
module tb_incr9_share_arb;
   localparam int NREQ = 4;
   localparam int IDW  = $clog2(NREQ);

   typedef struct packed {
      logic [IDW-1:0] id;
      logic [8:0]     data;
      logic           cy;
   } rsp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   rsp_t           sb_q[$];
   logic           m_valid = 1'b0;
   int             m_ptr   = 0;
   int             chk_w;
   logic [NREQ-1:0] chk_ready;

   incr9_share_arb_if #(.NREQ(NREQ)) bus_if ();

   incr9_share_arb #(.NREQ(NREQ)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_if (bus_if)
   );

   always #5 clk = ~clk;

   function automatic int model_winner(input logic [NREQ-1:0] v, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         int i;
         i = (ptr + k) % NREQ;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic rsp_t expect_rsp(input logic [NREQ*9-1:0] d, input int w);
      rsp_t       r;
      logic [9:0] sum;
      sum    = {1'b0, d[9*w +: 9]} + 10'd1;
      r.id   = IDW'(w);
      r.data = sum[8:0];
      r.cy   = sum[9];
      return r;
   endfunction

   // Reference model: pushes the expected result at each acceptance, pops on drain.
   always @(posedge clk) begin
      if (rst) begin
         sb_q.delete();
         m_valid <= 1'b0;
         m_ptr   <= 0;
      end else begin
         if (m_valid && bus_if.rsp_ready) void'(sb_q.pop_front());
         if ((!m_valid || bus_if.rsp_ready) && model_winner(bus_if.req_valid, m_ptr) >= 0) begin
            sb_q.push_back(expect_rsp(bus_if.req_data, model_winner(bus_if.req_valid, m_ptr)));
            m_valid <= 1'b1;
            m_ptr   <= (model_winner(bus_if.req_valid, m_ptr) + 1) % NREQ;
         end else if (bus_if.rsp_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

   // Mid-cycle scoreboard comparison against the model.
   always @(negedge clk) begin
      chk_w     = model_winner(bus_if.req_valid, m_ptr);
      chk_ready = '0;
      if (!rst && (!m_valid || bus_if.rsp_ready) && chk_w >= 0) chk_ready[chk_w] = 1'b1;
      checks++;
      if (bus_if.req_ready !== chk_ready) begin
         errors++;
         $display("FAIL sb_req_ready t=%0t: got %b expected %b", $time, bus_if.req_ready, chk_ready);
      end
      checks++;
      if (bus_if.rsp_valid !== m_valid) begin
         errors++;
         $display("FAIL sb_rsp_valid t=%0t: got %b expected %b", $time, bus_if.rsp_valid, m_valid);
      end
      if (m_valid) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_empty t=%0t: result present but nothing expected", $time);
         end else if ({bus_if.rsp_id, bus_if.rsp_data, bus_if.rsp_cy} !== sb_q[0]) begin
            errors++;
            $display("FAIL sb_rsp t=%0t: got id=%0d data=%h cy=%b expected id=%0d data=%h cy=%b",
                     $time, bus_if.rsp_id, bus_if.rsp_data, bus_if.rsp_cy,
                     sb_q[0].id, sb_q[0].data, sb_q[0].cy);
         end
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus_if.req_valid = '1;
      bus_if.req_data  = {9'h010, 9'h1FF, 9'h0FF, 9'h005};
      bus_if.rsp_ready = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checks++;
         if (bus_if.req_ready !== 4'b0000 || bus_if.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_hs: got ready=%b valid=%b expected ready=0000 valid=0",
                     bus_if.req_ready, bus_if.rsp_valid);
         end
         checks++;
         if (bus_if.rsp_data !== 9'h000 || bus_if.rsp_cy !== 1'b0 || bus_if.rsp_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_out: got data=%h cy=%b id=%0d expected 000/0/0",
                     bus_if.rsp_data, bus_if.rsp_cy, bus_if.rsp_id);
         end
         next_cycle();
      end
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL reset_first_grant: got %b expected 0001", bus_if.req_ready);
      end
      next_cycle();
   endtask

   task automatic test_rotation();
      logic [8:0] exp_data [4] = '{9'h006, 9'h100, 9'h000, 9'h011};
      logic       exp_cy   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         checks++;
         if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_id !== IDW'(k % 4) ||
             bus_if.rsp_data !== exp_data[k % 4] || bus_if.rsp_cy !== exp_cy[k % 4]) begin
            errors++;
            $display("FAIL rotation[%0d]: got v=%b id=%0d data=%h cy=%b expected v=1 id=%0d data=%h cy=%b",
                     k, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.rsp_cy,
                     k % 4, exp_data[k % 4], exp_cy[k % 4]);
         end
         next_cycle();
      end
   endtask

   task automatic test_backpressure();
      bus_if.rsp_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         checks++;
         if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_id !== 2'd0 ||
             bus_if.rsp_data !== 9'h006 || bus_if.rsp_cy !== 1'b0 || bus_if.req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got v=%b id=%0d data=%h cy=%b ready=%b expected 1/0/006/0/0000",
                     k, bus_if.rsp_valid, bus_if.rsp_id, bus_if.rsp_data, bus_if.rsp_cy, bus_if.req_ready);
         end
         next_cycle();
      end
      bus_if.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL bp_release_ready: got %b expected 0010", bus_if.req_ready);
      end
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus_if.rsp_id !== 2'd1 || bus_if.rsp_data !== 9'h100) begin
         errors++;
         $display("FAIL bp_release_rsp: got id=%0d data=%h expected id=1 data=100",
                  bus_if.rsp_id, bus_if.rsp_data);
      end
      next_cycle();
   endtask

   task automatic test_walk();
      logic [8:0] ops      [4] = '{9'h1FD, 9'h1FE, 9'h1FF, 9'h000};
      logic [8:0] exp_data [4] = '{9'h1FE, 9'h1FF, 9'h000, 9'h001};
      logic       exp_cy   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      bus_if.req_valid = 4'b0100;
      for (int i = 0; i < 4; i++) begin
         bus_if.req_data[18 +: 9] = ops[i];
         @(negedge clk);
         checks++;
         if (bus_if.req_ready !== 4'b0100) begin
            errors++;
            $display("FAIL walk_ready[%0d]: got %b expected 0100", i, bus_if.req_ready);
         end
         if (i > 0) begin
            checks++;
            if (bus_if.rsp_id !== 2'd2 || bus_if.rsp_data !== exp_data[i-1] || bus_if.rsp_cy !== exp_cy[i-1]) begin
               errors++;
               $display("FAIL walk_rsp[%0d]: got id=%0d data=%h cy=%b expected id=2 data=%h cy=%b",
                        i - 1, bus_if.rsp_id, bus_if.rsp_data, bus_if.rsp_cy, exp_data[i-1], exp_cy[i-1]);
            end
         end
         next_cycle();
      end
      bus_if.req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (bus_if.rsp_data !== exp_data[3] || bus_if.rsp_cy !== exp_cy[3]) begin
         errors++;
         $display("FAIL walk_rsp[3]: got data=%h cy=%b expected data=%h cy=%b",
                  bus_if.rsp_data, bus_if.rsp_cy, exp_data[3], exp_cy[3]);
      end
      next_cycle();
   endtask

   task automatic test_rr_ptr();
      int exp_id [3] = '{3, 1, 3};
      // A grant to requester 2 leaves the pointer at 3.
      bus_if.req_valid = 4'b0100;
      bus_if.req_data[18 +: 9] = 9'h0AA;
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 4'b0100) begin
         errors++;
         $display("FAIL rr_setup: got %b expected 0100", bus_if.req_ready);
      end
      next_cycle();
      bus_if.req_valid = 4'b1010;
      bus_if.req_data[9 +: 9]  = 9'h123;
      bus_if.req_data[27 +: 9] = 9'h0FE;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++;
         if (bus_if.req_ready !== NREQ'(1 << exp_id[k])) begin
            errors++;
            $display("FAIL rr_grant[%0d]: got %b expected req %0d", k, bus_if.req_ready, exp_id[k]);
         end
         if (k > 0) begin
            checks++;
            if (bus_if.rsp_id !== IDW'(exp_id[k-1])) begin
               errors++;
               $display("FAIL rr_id[%0d]: got %0d expected %0d", k - 1, bus_if.rsp_id, exp_id[k-1]);
            end
         end
         next_cycle();
      end
      bus_if.req_valid = 4'b0010;
      @(negedge clk);
      checks++;
      if (bus_if.rsp_id !== 2'd3 || bus_if.req_ready !== 4'b0010) begin
         errors++;
         $display("FAIL rr_tail: got id=%0d ready=%b expected id=3 ready=0010", bus_if.rsp_id, bus_if.req_ready);
      end
      next_cycle();
      bus_if.req_valid = 4'b0000;
      @(negedge clk);
      checks++;
      if (bus_if.rsp_id !== 2'd1 || bus_if.rsp_data !== 9'h124) begin
         errors++;
         $display("FAIL rr_last: got id=%0d data=%h expected id=1 data=124", bus_if.rsp_id, bus_if.rsp_data);
      end
      next_cycle();
   endtask

   task automatic test_reset_mid();
      bus_if.req_valid = 4'b0010;
      bus_if.req_data[9 +: 9] = 9'h044;
      bus_if.rsp_ready = 1'b1;
      next_cycle();
      bus_if.rsp_ready = 1'b0;
      bus_if.req_valid = 4'b1111;
      bus_if.req_data[0 +: 9] = 9'h033;
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 1'b1 || bus_if.rsp_id !== 2'd1 || bus_if.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_held: got v=%b id=%0d ready=%b expected 1/1/0000",
                  bus_if.rsp_valid, bus_if.rsp_id, bus_if.req_ready);
      end
      next_cycle();
      rst = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL rstmid_ready: got %b expected 0000", bus_if.req_ready);
      end
      next_cycle();
      rst = 1'b0;
      bus_if.rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || bus_if.rsp_data !== 9'h000 || bus_if.req_ready !== 4'b0001) begin
         errors++;
         $display("FAIL rstmid_after: got v=%b data=%h ready=%b expected 0/000/0001",
                  bus_if.rsp_valid, bus_if.rsp_data, bus_if.req_ready);
      end
      repeat (4) next_cycle();
      bus_if.req_valid = 4'b0000;
      next_cycle();
      @(negedge clk);
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || sb_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got v=%b pending=%0d expected 0/0", bus_if.rsp_valid, sb_q.size());
      end
   endtask

   initial begin
      bus_if.req_valid = '0;
      bus_if.req_data  = '0;
      bus_if.rsp_ready = 1'b0;
      test_reset();
      test_rotation();
      test_backpressure();
      test_walk();
      test_rr_ptr();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
